// File: rtl/max_pooling_2x2.sv
// 2x2 stride-2 signed max pooling over a raster, channel-interleaved pixel stream.
// Horizontal pairs reduce in a per-channel holding register; vertical pairs meet through a half-line buffer.
module max_pooling_2x2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int STRING_LEN  = 224,
  parameter int STRING_NUM  = 224,
  parameter int CHANNEL_NUM = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         valid_i,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic                         sof_i,
  input  logic                         eof_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         err_o
);

  localparam int DEPTH = CHANNEL_NUM * STRING_LEN / 2;
  localparam int CW    = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int LW    = $clog2(STRING_LEN);
  localparam int NW    = $clog2(STRING_NUM);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] chan_q, chan_d, pchan;
  logic [LW-1:0] col_q, col_d, pcol;
  logic [NW-1:0] row_q, row_d, prow;
  logic          synced_q, synced_d, err_q, err_d;
  logic          last_chan, last_col, last_row, line_start, act, frame_err;
  logic          m_sop, m_eop, m_sof, m_eof;

  logic          vld_p1, wr_p1, vld_p2;
  logic [3:0]    mk_p1, mk_p2;
  logic [AW-1:0] addr_p1;
  sample_t       h_p1, h_p2, lb_p2;
  sample_t       hreg_q  [2**CW];
  sample_t       linebuf [DEPTH];

  // Stage 0: position of the current sample, with line/frame markers overriding the counters
  always_comb begin
    pchan = chan_q;
    pcol  = col_q;
    prow  = row_q;
    if (sof_i) begin
      pchan = '0;
      pcol  = '0;
      prow  = '0;
    end else if (sop_i) begin
      pchan = '0;
      pcol  = '0;
    end
  end

  assign last_chan  = (pchan == CW'(CHANNEL_NUM - 1));
  assign last_col   = (pcol == LW'(STRING_LEN - 1));
  assign last_row   = (prow == NW'(STRING_NUM - 1));
  assign line_start = (pchan == '0) && (pcol == '0);
  assign act        = valid_i && (synced_q || sof_i);

  assign m_sop = (pchan == '0) && (pcol == LW'(1));
  assign m_eop = last_chan && last_col;
  assign m_sof = m_sop && (prow == NW'(1));
  assign m_eof = m_eop && last_row;

  always_comb begin
    frame_err = 1'b0;
    if (valid_i) begin
      if (eop_i != (last_chan && last_col))             frame_err = 1'b1;
      if (eof_i != (last_chan && last_col && last_row)) frame_err = 1'b1;
      if (line_start && !sop_i)                         frame_err = 1'b1;
      // A marker that cuts a line or frame short means its eop_i/eof_i never arrived.
      if ((sop_i || sof_i) && ((chan_q != '0) || (col_q != '0))) frame_err = 1'b1;
      if (sof_i && (row_q != '0))                       frame_err = 1'b1;
    end
  end

  always_comb begin
    chan_d   = chan_q;
    col_d    = col_q;
    row_d    = row_q;
    synced_d = synced_q || (valid_i && sof_i);
    err_d    = err_q || frame_err;
    if (valid_i) begin
      chan_d = last_chan ? '0 : pchan + 1'b1;
      col_d  = !last_chan ? pcol : (last_col ? '0 : pcol + 1'b1);
      row_d  = !(last_chan && last_col) ? prow : (last_row ? '0 : prow + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      synced_q <= 1'b0;
      err_q    <= 1'b0;
      vld_p1   <= 1'b0;
      wr_p1    <= 1'b0;
      mk_p1    <= '0;
      vld_p2   <= 1'b0;
      mk_p2    <= '0;
    end else begin
      chan_q   <= chan_d;
      col_q    <= col_d;
      row_q    <= row_d;
      synced_q <= synced_d;
      err_q    <= err_d;
      vld_p1   <= act && pcol[0] && prow[0];
      wr_p1    <= act && pcol[0] && !prow[0];
      mk_p1    <= {m_sop, m_eop, m_sof, m_eof};
      vld_p2   <= vld_p1;
      mk_p2    <= mk_p1;
    end
  end

  // Stage 1: horizontal max registered with its line-buffer address
  always_ff @(posedge clk) begin
    if (act && !pcol[0]) hreg_q[pchan] <= data_i;
    h_p1    <= smax(hreg_q[pchan], data_i);
    addr_p1 <= AW'(((32'(pcol) >> 1) * 32'(CHANNEL_NUM)) + 32'(pchan));
  end

  // Stage 2: even rows fill the line buffer, odd rows read the partner row back
  always_ff @(posedge clk) begin
    if (wr_p1) linebuf[addr_p1] <= h_p1;
    lb_p2 <= linebuf[addr_p1];
    h_p2  <= h_p1;
  end

  assign data_valid_o = vld_p2;
  assign data_o       = vld_p2 ? smax(h_p2, lb_p2) : '0;
  assign {sop_o, eop_o, sof_o, eof_o} = mk_p2 & {4{vld_p2}};
  assign err_o        = err_q;

endmodule
